// File: rtl/rv32i_types_pkg.sv
// Shared integer-pipeline types: writeback request record and source indices.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [4:0] rd;
    word_t      data;
  } wb_req_t;

  localparam int unsigned WB_SRC_ALU    = 0;
  localparam int unsigned WB_SRC_MULDIV = 1;
  localparam int unsigned WB_SRC_LSU    = 2;

  // Source-index width; stays 1 bit wide for a single source.
  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32i_wb_arbiter_if.sv
// Result-source and register-file write-port bundle for the writeback arbiter.
interface rv32i_wb_arbiter_if
  import rv32i_types_pkg::*;
#(
  parameter int unsigned NUM_SRC = 3
);
  localparam int unsigned SRC_W = src_w(NUM_SRC);

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [NUM_SRC-1:0][4:0]  src_rd;
  logic [NUM_SRC-1:0][31:0] src_data;
  logic                     wb_wen;
  logic [4:0]               wb_rd;
  word_t                    wb_data;
  logic [SRC_W-1:0]         wb_src;
  logic                     idle;

  modport slave (
    input  src_valid, src_rd, src_data,
    output src_ready, wb_wen, wb_rd, wb_data, wb_src, idle
  );

  modport master (
    output src_valid, src_rd, src_data,
    input  src_ready, wb_wen, wb_rd, wb_data, wb_src, idle
  );

endinterface

// File: rtl/rv32i_wb_fifo.sv
// Per-source result FIFO; power-of-two depth so pointers wrap by overflow.
module rv32i_wb_fifo
  import rv32i_types_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_req;
  end

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs, round-robin grant, one registered
// register-file write per cycle.
module rv32i_wb_arbiter
  import rv32i_types_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                CLK,
  input logic                RST,
  rv32i_wb_arbiter_if.slave  bus
);
  localparam int unsigned SRC_W = src_w(NUM_SRC);

  logic [NUM_SRC-1:0] push, pop, full, empty;
  wb_req_t            head [NUM_SRC];

  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   rr_q, rr_d;

  logic               wen_q;
  logic [4:0]         rd_q;
  word_t              data_q;
  logic [SRC_W-1:0]   src_q;

  // Writes to x0 complete the handshake but are never buffered.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push[g] = bus.src_valid[g] & ~full[g] & (bus.src_rd[g] != 5'd0);

    rv32i_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .push     (push[g]),
      .push_req ({bus.src_rd[g], bus.src_data[g]}),
      .pop      (pop[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .head     (head[g])
    );
  end

  assign bus.src_ready = ~full;

  always_comb begin
    int unsigned      idx;
    logic [SRC_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = SRC_W'(idx);
      if (!gnt_valid && !empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end

    pop = '0;
    if (gnt_valid) pop[gnt_idx] = 1'b1;

    rr_d = rr_q;
    if (gnt_valid)
      rr_d = (32'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q   <= '0;
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      rr_q  <= rr_d;
      wen_q <= gnt_valid;
      if (gnt_valid) begin
        rd_q   <= head[gnt_idx].rd;
        data_q <= head[gnt_idx].data;
        src_q  <= gnt_idx;
      end
    end
  end

  assign bus.wb_wen  = wen_q;
  assign bus.wb_rd   = rd_q;
  assign bus.wb_data = data_q;
  assign bus.wb_src  = src_q;
  assign bus.idle    = (&empty) & ~wen_q;

endmodule
